// File: rtl/run_tx_pkg.sv
// Shared types and default widths for the run-length transmitter.
package run_tx_pkg;

  localparam int DEF_LEN_W = 8;
  localparam int DEF_GAP_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, GAP} run_state_t;

  typedef struct packed {
    logic [DEF_LEN_W-1:0] len;
    logic [DEF_GAP_W-1:0] gap;
  } run_cmd_t;

endpackage

// File: rtl/run_tx_cmd_fifo.sv
// Generic synchronous FIFO with flush; head shows the oldest entry when non-empty.
module cmd_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  T     din,
  output logic full,
  output logic empty,
  output T     head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           push_ok;
  logic           pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/run_tx.sv
// Serial run-length transmitter: each queued (len, gap) command drives w high
// for len cycles then low for gap cycles, chaining commands without bubbles.
module run_tx
  import run_tx_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [GAP_W-1:0] cmd_gap,
  input  logic             abort,
  output logic             w,
  output logic             busy,
  output logic             done
);

  localparam int CW = (LEN_W > GAP_W) ? LEN_W : GAP_W;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [GAP_W-1:0] gap;
  } cmd_t;

  cmd_t             in_cmd;
  cmd_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  run_state_t       state;
  run_state_t       state_n;
  run_state_t       ld_state;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [CW-1:0]    ld_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_n;
  logic             ld_last;
  logic             last_n;
  logic             fin;
  logic             w_n;
  logic             done_n;
  logic             busy_n;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !abort;
  assign in_cmd    = '{len: cmd_len, gap: cmd_gap};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .din     (in_cmd),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // A (0,0) command is a single low cycle that is also its last: same as (0,1).
  always_comb begin
    ld_state = GAP;
    ld_cnt   = '0;
    ld_last  = 1'b0;
    if (head.len != '0) begin
      ld_state = RUN;
      ld_cnt   = CW'(head.len - LEN_W'(1));
      ld_last  = (head.len == LEN_W'(1)) && (head.gap == '0);
    end else begin
      ld_cnt   = (head.gap == '0) ? '0 : CW'(head.gap - GAP_W'(1));
      ld_last  = (head.gap <= GAP_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      gap_q <= '0;
      w     <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      gap_q <= gap_n;
      w     <= w_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  // last_n flags that the coming cycle is the final cycle of the command.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gap_n   = gap_q;
    last_n  = 1'b0;
    pop     = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: fin = 1'b1;
      RUN: begin
        if (cnt != '0) begin
          cnt_n  = cnt - CW'(1);
          last_n = (cnt == CW'(1)) && (gap_q == '0);
        end else if (gap_q != '0) begin
          state_n = GAP;
          cnt_n   = CW'(gap_q - GAP_W'(1));
          last_n  = (gap_q == GAP_W'(1));
        end else begin
          fin = 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n  = cnt - CW'(1);
          last_n = (cnt == CW'(1));
        end else begin
          fin = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (fin) begin
      if (!empty) begin
        pop     = 1'b1;
        state_n = ld_state;
        cnt_n   = ld_cnt;
        gap_n   = head.gap;
        last_n  = ld_last;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      pop     = 1'b0;
      last_n  = 1'b0;
    end
  end

  always_comb begin
    w_n    = (state_n == RUN);
    done_n = last_n;
    busy_n = !abort && ((state_n != IDLE) || push || !empty);
  end

endmodule

// File: tb/tb_run_tx.sv
// Self-checking bench for run_tx: vector table, handshake/abort sequences and
// randomized traffic against a cycle-timeline reference model.
module tb_run_tx;
  import run_tx_pkg::*;

  localparam int DEPTH = 2;
  localparam int NC    = 4096;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [7:0] cmd_gap;
  logic       abort;
  logic       w;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int cyc;
  int free_at;
  int ndone;
  int hits;
  int pend[$];
  bit ew[NC];
  bit ed[NC];
  bit eb[NC];
  bit prev_w;
  bit prev_det;

  typedef struct {
    bit v;
    int l;
    int g;
    bit ew;
    bit ed;
    bit eb;
    bit er;
  } vec_t;

  vec_t tbl[$];

  run_tx #(.LEN_W(8), .GAP_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_gap   (cmd_gap),
    .abort     (abort),
    .w         (w),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  // Advance one edge; also runs a two-consecutive-ones detector on w.
  task automatic tick();
    bit det;
    @(posedge clk);
    #1;
    cyc++;
    while (pend.size() > 0 && pend[0] <= cyc) pend.delete(0);
    if (done) ndone++;
    det = w && prev_w;
    if (det && !prev_det) hits++;
    prev_w   = w;
    prev_det = det;
  endtask

  task automatic model_clear();
    foreach (ew[i]) begin
      ew[i] = 1'b0;
      ed[i] = 1'b0;
      eb[i] = 1'b0;
    end
    pend.delete();
    free_at = 0;
  endtask

  // Command accepted at edge a occupies the line from max(a+1, free_at)
  // for len+gap cycles (one cycle if both are zero).
  task automatic add_cmd(input int a, input int l, input int g);
    int s;
    int n;
    s = (free_at > a + 1) ? free_at : a + 1;
    n = (l + g == 0) ? 1 : l + g;
    for (int c = a; c < s + n && c < NC; c++) eb[c] = 1'b1;
    for (int c = s; c < s + n && c < NC; c++) begin
      ew[c] = (c < s + l);
      ed[c] = (c == s + n - 1);
    end
    free_at = s + n;
    pend.push_back(s);
  endtask

  task automatic apply(input bit v, input int l, input int g, output bit acc);
    bit r;
    r = (pend.size() < DEPTH);
    chk("ready", cmd_ready, r);
    acc       = v && r;
    cmd_valid = v;
    cmd_len   = 8'(l);
    cmd_gap   = 8'(g);
    if (acc) add_cmd(cyc + 1, l, g);
    tick();
    cmd_valid = 1'b0;
    chk("w", w, ew[cyc]);
    chk("done", done, ed[cyc]);
    chk("busy", busy, eb[cyc]);
  endtask

  initial begin
    bit acc;
    int nd0;
    int p0;
    int er;
    int run;
    int ql[3];
    int qg[3];
    run_cmd_t rc;

    checks = 0; errors = 0; cyc = 0; ndone = 0; hits = 0;
    prev_w = 1'b0; prev_det = 1'b0; free_at = 0;
    reset_n = 1'b0; abort = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_gap = '0;

    tick();
    tick();
    chk("reset_w", w, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ready", cmd_ready, 1);
    reset_n = 1'b1;

    // Columns: valid, len, gap, then w, done, busy, ready after that edge.
    tbl.push_back('{1'b1, 3, 2, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1, 3, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 0, 4, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      cmd_valid = tbl[i].v;
      cmd_len   = 8'(tbl[i].l);
      cmd_gap   = 8'(tbl[i].g);
      tick();
      cmd_valid = 1'b0;
      chk($sformatf("tbl%0d_w", i), w, tbl[i].ew);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].er);
    end

    // Backpressure: long run plus three more commands against a 2-deep FIFO.
    model_clear();
    nd0 = ndone;
    ql = '{1, 2, 3};
    qg = '{0, 1, 0};
    apply(1'b1, 10, 0, acc);
    for (int k = 0; k < 3; k++) begin
      int tries;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 40) begin
        apply(1'b1, ql[k], qg[k], acc);
        tries++;
      end
      if (!acc) chk("hold_timeout", 0, 1);
      if (k == 1) chk("ready_full", cmd_ready, 0);
      if (k == 2) chk("held_cycles", int'(tries > 1), 1);
    end
    repeat (40) apply(1'b0, 0, 0, acc);
    chk("no_loss_done", ndone - nd0, 4);

    // Abort, then reset, in the third run cycle of (8,8) with one queued.
    for (int pass = 0; pass < 2; pass++) begin
      model_clear();
      nd0 = ndone;
      apply(1'b1, 8, 8, acc);
      apply(1'b1, 1, 1, acc);
      apply(1'b0, 0, 0, acc);
      apply(1'b0, 0, 0, acc);
      chk("pre_abort_w", w, 1);
      cmd_valid = 1'b1;
      cmd_len   = 8'd2;
      cmd_gap   = 8'd2;
      if (pass == 0) abort = 1'b1;
      else           reset_n = 1'b0;
      tick();
      abort = 1'b0; reset_n = 1'b1; cmd_valid = 1'b0;
      chk($sformatf("flush%0d_w", pass), w, 0);
      chk($sformatf("flush%0d_busy", pass), busy, 0);
      chk($sformatf("flush%0d_done", pass), done, 0);
      chk($sformatf("flush%0d_ready", pass), cmd_ready, 1);
      repeat (12) begin
        tick();
        chk($sformatf("flush%0d_idle_w", pass), w, 0);
        chk($sformatf("flush%0d_idle_busy", pass), busy, 0);
      end
      chk($sformatf("flush%0d_no_done", pass), ndone - nd0, 0);
    end

    // Randomized traffic against the timeline model.
    model_clear();
    hits = 0; prev_w = 1'b0; prev_det = 1'b0;
    p0 = cyc;
    repeat (800) begin
      rc.len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
      rc.gap = 8'($urandom_range(0, 3));
      apply($urandom_range(0, 3) != 0, int'(rc.len), int'(rc.gap), acc);
    end
    repeat (80) apply(1'b0, 0, 0, acc);

    er = 0;
    run = 0;
    for (int c = p0 + 1; c <= cyc; c++) begin
      if (ew[c]) run++;
      else begin
        if (run >= 2) er++;
        run = 0;
      end
    end
    chk("detector_runs", hits, er);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
